// File: rtl/xy_noc_pkg.sv
// Shared XY-mesh packet definitions, used by both xy_switch and xy_resource_ni.
package xy_noc_pkg;

    localparam int PACKET_ADDR_X_W = 4;
    localparam int PACKET_ADDR_Y_W = 4;
    localparam int PACKET_DATA_W   = 8;
    localparam int PACKET_W        = PACKET_ADDR_X_W + PACKET_ADDR_Y_W + PACKET_DATA_W;

    // Switch port directions
    localparam int LEFT  = 0;
    localparam int TOP   = 1;
    localparam int RIGHT = 2;
    localparam int BOT   = 3;

    // Field slice offsets inside a packet
    localparam int PKT_DATA_LSB = 0;
    localparam int PKT_Y_LSB    = PKT_DATA_LSB + PACKET_DATA_W;
    localparam int PKT_X_LSB    = PKT_Y_LSB + PACKET_ADDR_Y_W;

    typedef struct packed {
        logic [PACKET_ADDR_X_W-1:0] x;
        logic [PACKET_ADDR_Y_W-1:0] y;
        logic [PACKET_DATA_W-1:0]   data;
    } packet_t;

endpackage

// File: rtl/ni_sync_fifo.sv
// Single-clock FIFO with registered storage; push is ignored when full and
// pop is ignored when empty. DEPTH must be a power of two (>= 2).
module ni_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q;
    logic [AW-1:0]               wr_ptr_q, rd_ptr_q;
    logic [AW:0]                 cnt_q;
    logic                        do_push, do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    // Storage and pointers; storage is cleared so the head reads 0 out of reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Occupancy: simultaneous push and pop leave it unchanged
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            cnt_q <= '0;
        else if (do_push && !do_pop)
            cnt_q <= cnt_q + 1'b1;
        else if (do_pop && !do_push)
            cnt_q <= cnt_q - 1'b1;
    end

endmodule

// File: rtl/xy_resource_ni.sv
// Resource-side network interface for the XY mesh: TX FIFO towards the local
// switch, single-entry RX buffer from it, plus traffic counters.
// Optional: NI_RX_ADDR_CHECK_EN drops (and counts) received packets whose
// address is not this node.
module xy_resource_ni
    import xy_noc_pkg::*;
#(
    parameter int X_CORD        = 0,
    parameter int Y_CORD        = 0,
    parameter int TX_FIFO_DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       tx_vld_i,
    input  logic [PACKET_ADDR_X_W-1:0] tx_x_i,
    input  logic [PACKET_ADDR_Y_W-1:0] tx_y_i,
    input  logic [PACKET_DATA_W-1:0]   tx_data_i,
    output logic                       tx_rdy_o,
    output logic                       pckt_vld_o,
    output logic [PACKET_W-1:0]        pckt_o,
    input  logic                       pckt_rd_i,
    input  logic                       pckt_vld_i,
    input  logic [PACKET_W-1:0]        pckt_i,
    output logic                       pckt_rd_o,
    output logic                       rx_vld_o,
    output logic [PACKET_ADDR_X_W-1:0] rx_x_o,
    output logic [PACKET_ADDR_Y_W-1:0] rx_y_o,
    output logic [PACKET_DATA_W-1:0]   rx_data_o,
    input  logic                       rx_rd_i,
    output logic [7:0]                 tx_cnt_o,
    output logic [7:0]                 rx_cnt_o,
    output logic [7:0]                 misroute_cnt_o,
    output logic                       busy_o
);

`ifdef NI_RX_ADDR_CHECK_EN
    localparam bit ADDR_CHECK = 1'b1;
`else
    localparam bit ADDR_CHECK = 1'b0;
`endif

    localparam logic [PACKET_ADDR_X_W-1:0] OWN_X = PACKET_ADDR_X_W'(X_CORD);
    localparam logic [PACKET_ADDR_Y_W-1:0] OWN_Y = PACKET_ADDR_Y_W'(Y_CORD);

    // ---------------- TX path ----------------
    packet_t tx_pkt;
    logic    tx_full, tx_empty, tx_push, tx_pop;

    assign tx_pkt     = '{x: tx_x_i, y: tx_y_i, data: tx_data_i};
    assign tx_rdy_o   = ~tx_full;
    assign tx_push    = tx_vld_i & tx_rdy_o;
    assign pckt_vld_o = ~tx_empty;
    assign tx_pop     = pckt_vld_o & pckt_rd_i;

    ni_sync_fifo #(
        .WIDTH (PACKET_W),
        .DEPTH (TX_FIFO_DEPTH)
    ) u_tx_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (tx_push),
        .wdata_i (tx_pkt),
        .pop_i   (tx_pop),
        .rdata_o (pckt_o),
        .full_o  (tx_full),
        .empty_o (tx_empty)
    );

    // ---------------- RX path ----------------
    packet_t rx_in, rx_pkt_q;
    logic    rx_vld_q, rx_accept, rx_addr_ok, rx_store, rx_misroute, rx_drain;
    logic [7:0] tx_cnt_q, rx_cnt_q, mis_cnt_q;

    assign rx_in       = packet_t'(pckt_i);
    assign pckt_rd_o   = ~rx_vld_q;
    assign rx_accept   = pckt_vld_i & pckt_rd_o;
    assign rx_addr_ok  = (rx_in.x == OWN_X) && (rx_in.y == OWN_Y);
    // Without the address check every accepted packet is stored
    assign rx_store    = rx_accept & (rx_addr_ok | ~ADDR_CHECK);
    assign rx_misroute = rx_accept & ~rx_addr_ok & ADDR_CHECK;
    assign rx_drain    = rx_vld_q & rx_rd_i;

    // Single-entry RX buffer; full buffer blocks accepts, so fill and drain never overlap
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_vld_q <= 1'b0;
            rx_pkt_q <= '0;
        end else if (rx_drain) begin
            rx_vld_q <= 1'b0;
        end else if (rx_store) begin
            rx_vld_q <= 1'b1;
            rx_pkt_q <= rx_in;
        end
    end

    // Traffic counters: TX/RX wrap, misroute saturates
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_cnt_q  <= '0;
            rx_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else begin
            if (tx_pop)                          tx_cnt_q  <= tx_cnt_q + 1'b1;
            if (rx_drain)                        rx_cnt_q  <= rx_cnt_q + 1'b1;
            if (rx_misroute && mis_cnt_q != '1)  mis_cnt_q <= mis_cnt_q + 1'b1;
        end
    end

    assign rx_vld_o       = rx_vld_q;
    assign rx_x_o         = rx_pkt_q.x;
    assign rx_y_o         = rx_pkt_q.y;
    assign rx_data_o      = rx_pkt_q.data;
    assign tx_cnt_o       = tx_cnt_q;
    assign rx_cnt_o       = rx_cnt_q;
    assign misroute_cnt_o = mis_cnt_q;
    assign busy_o         = ~tx_empty | rx_vld_q;

endmodule
